// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
package truth_table_pkg;

   localparam int unsigned VEC_W   = 3;
   localparam int unsigned TABLE_W = 8;
   localparam logic [TABLE_W-1:0] DEFAULT_EXPECTED = 8'h3D;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      SAMPLE,
      DONE
   } state_t;

endpackage

// File: rtl/truth_table_sweeper_settle_timer.sv
// Settle-window counter: counts cycles a vector has been driven, flags TERMINAL.
module sweep_settle_timer #(
   parameter int unsigned TERMINAL = 3,
   parameter int unsigned CNT_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic load,
   input  logic en,
   output logic term_c
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load value 1: the first cycle of a new vector is already one held cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = CNT_W'(1);
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign term_c = (cnt_q == CNT_W'(TERMINAL));

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 8 input vectors of a 3-input gate, samples its output after a
// settle window and assembles/compares the 8-bit truth-table code.
module truth_table_sweeper
   import truth_table_pkg::*;
#(
   parameter int unsigned        SETTLE_CYCLES = 3,
   parameter logic [TABLE_W-1:0] EXPECTED      = DEFAULT_EXPECTED
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               out,
   output logic               in1,
   output logic               in2,
   output logic               in3,
   output logic               busy,
   output logic               done,
   output logic               valid,
   output logic [TABLE_W-1:0] table_code,
   output logic               match
);

   // With no settle window each vector lives only in SAMPLE.
   localparam state_t FIRST_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : HOLD;

   state_t             state_q, state_d;
   logic [VEC_W-1:0]   idx_q, idx_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic [TABLE_W-1:0] table_q, table_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               valid_q, valid_d;
   logic               match_q, match_d;

   logic timer_clr, timer_load, timer_en, timer_term_c;

   sweep_settle_timer #(
      .TERMINAL (SETTLE_CYCLES),
      .CNT_W    (8)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clr    (timer_clr),
      .load   (timer_load),
      .en     (timer_en),
      .term_c (timer_term_c)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      table_d    = table_q;
      valid_d    = valid_q;
      match_d    = match_q;
      done_d     = 1'b0;
      timer_clr  = 1'b0;
      timer_load = 1'b0;
      timer_en   = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = FIRST_STATE;
               idx_d      = '0;
               table_d    = '0;
               valid_d    = 1'b0;
               match_d    = 1'b0;
               timer_load = 1'b1;
            end
         end
         HOLD: begin
            if (timer_term_c) begin
               state_d = SAMPLE;
            end else begin
               timer_en = 1'b1;
            end
         end
         SAMPLE: begin
            // Vector 000 lands in the MSB.
            table_d[3'(3'd7 - idx_q)] = out;
            if (idx_q == 3'd7) begin
               state_d   = DONE;
               done_d    = 1'b1;
               valid_d   = 1'b1;
               match_d   = (table_d == EXPECTED);
               timer_clr = 1'b1;
            end else begin
               state_d    = FIRST_STATE;
               idx_d      = idx_q + 3'd1;
               timer_load = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == HOLD) || (state_d == SAMPLE);
      vec_d  = busy_d ? idx_d : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         vec_q   <= '0;
         table_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         vec_q   <= vec_d;
         table_q <= table_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         match_q <= match_d;
      end
   end

   assign in1        = vec_q[2];
   assign in2        = vec_q[1];
   assign in3        = vec_q[0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign valid      = valid_q;
   assign table_code = table_q;
   assign match      = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: three sweepers (settle 3, settle 0, expected 0xBC) against a modelled gate.
module tb_truth_table_sweeper;

   logic clk = 1'b0;
   logic rst;
   logic start;
   int   mode;  // 0: 0x3D gate, 1: stuck 0, 2: stuck 1, 3: 0x3D delayed 2 cycles
   int   n_tests = 0;
   int   n_fail  = 0;

   logic       a_in1, a_in2, a_in3, a_busy, a_done, a_valid, a_match, a_out;
   logic [7:0] a_code;
   logic       z_in1, z_in2, z_in3, z_busy, z_done, z_valid, z_match, z_out;
   logic [7:0] z_code;
   logic       b_in1, b_in2, b_in3, b_busy, b_done, b_valid, b_match, b_out;
   logic [7:0] b_code;
   logic       a_d1, a_d2, z_d1, z_d2, b_d1, b_d2;

   always #5 clk = ~clk;

   truth_table_sweeper #(.SETTLE_CYCLES(3), .EXPECTED(8'h3D)) dut_a (
      .clk(clk), .rst(rst), .start(start), .out(a_out),
      .in1(a_in1), .in2(a_in2), .in3(a_in3), .busy(a_busy), .done(a_done),
      .valid(a_valid), .table_code(a_code), .match(a_match));

   truth_table_sweeper #(.SETTLE_CYCLES(0), .EXPECTED(8'h3D)) dut_z (
      .clk(clk), .rst(rst), .start(start), .out(z_out),
      .in1(z_in1), .in2(z_in2), .in3(z_in3), .busy(z_busy), .done(z_done),
      .valid(z_valid), .table_code(z_code), .match(z_match));

   truth_table_sweeper #(.SETTLE_CYCLES(3), .EXPECTED(8'hBC)) dut_b (
      .clk(clk), .rst(rst), .start(start), .out(b_out),
      .in1(b_in1), .in2(b_in2), .in3(b_in3), .busy(b_busy), .done(b_done),
      .valid(b_valid), .table_code(b_code), .match(b_match));

   // Function 0x3D: out for vector v is bit (7-v) of the code.
   function automatic logic f3d(input logic [2:0] v);
      logic [7:0] t;
      t = 8'h3D;
      return t[3'd7 - v];
   endfunction

   always @(posedge clk) begin
      a_d1 <= f3d({a_in1, a_in2, a_in3});  a_d2 <= a_d1;
      z_d1 <= f3d({z_in1, z_in2, z_in3});  z_d2 <= z_d1;
      b_d1 <= f3d({b_in1, b_in2, b_in3});  b_d2 <= b_d1;
   end

   always_comb begin
      case (mode)
         0:       begin a_out = f3d({a_in1, a_in2, a_in3}); z_out = f3d({z_in1, z_in2, z_in3});
                        b_out = f3d({b_in1, b_in2, b_in3}); end
         1:       begin a_out = 1'b0; z_out = 1'b0; b_out = 1'b0; end
         2:       begin a_out = 1'b1; z_out = 1'b1; b_out = 1'b1; end
         default: begin a_out = a_d2; z_out = z_d2; b_out = b_d2; end
      endcase
   end

   // Pulse start for one cycle; return cycles-after-start of each first done (-1 = none).
   task automatic sweep(output int lat_a, output int lat_z, output int lat_b);
      lat_a = -1; lat_z = -1; lat_b = -1;
      start = 1'b1;
      for (int k = 1; k <= 200 && lat_a < 0; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (a_done && lat_a < 0) lat_a = k;
         if (z_done && lat_z < 0) lat_z = k;
         if (b_done && lat_b < 0) lat_b = k;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; mode = 0;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({a_in1, a_in2, a_in3, a_busy, a_done, a_valid, a_match} !== 7'b0) begin
         n_fail++; $display("FAIL reset_ctrl_a: got %b want 0000000",
                            {a_in1, a_in2, a_in3, a_busy, a_done, a_valid, a_match});
      end
      n_tests++;
      if (a_code !== 8'h00) begin
         n_fail++; $display("FAIL reset_code_a: got %h want 00", a_code);
      end
      n_tests++;
      if ({z_busy, z_done, z_valid, z_match, z_code, b_busy, b_done, b_valid, b_match, b_code} !== 24'h0) begin
         n_fail++; $display("FAIL reset_others: got %h want 000000",
                            {z_busy, z_done, z_valid, z_match, z_code, b_busy, b_done, b_valid, b_match, b_code});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_correct_gate();
      int la, lz, lb;
      mode = 0;
      sweep(la, lz, lb);
      n_tests++;
      if (la != 33) begin n_fail++; $display("FAIL latency_s3: got %0d want 33", la); end
      n_tests++;
      if (a_code !== 8'h3D || a_match !== 1'b1 || a_valid !== 1'b1) begin
         n_fail++; $display("FAIL correct_a: code %h match %b valid %b want 3d 1 1", a_code, a_match, a_valid);
      end
      n_tests++;
      if ({a_in1, a_in2, a_in3, a_busy} !== 4'b0000) begin
         n_fail++; $display("FAIL done_inputs_idle: got %b want 0000", {a_in1, a_in2, a_in3, a_busy});
      end
      n_tests++;
      if (lz != 9) begin n_fail++; $display("FAIL latency_s0: got %0d want 9", lz); end
      n_tests++;
      if (z_code !== 8'h3D || z_match !== 1'b1) begin
         n_fail++; $display("FAIL correct_s0: code %h match %b want 3d 1", z_code, z_match);
      end
      n_tests++;
      if (lb != 33 || b_code !== 8'h3D || b_match !== 1'b0 || b_valid !== 1'b1) begin
         n_fail++; $display("FAIL expected_bc: lat %0d code %h match %b valid %b want 33 3d 0 1",
                            lb, b_code, b_match, b_valid);
      end
      @(negedge clk);
      n_tests++;
      if (a_done !== 1'b0 || a_valid !== 1'b1 || a_code !== 8'h3D) begin
         n_fail++; $display("FAIL done_hold: done %b valid %b code %h want 0 1 3d", a_done, a_valid, a_code);
      end
   endtask

   task automatic test_stuck();
      int la, lz, lb;
      mode = 1;
      sweep(la, lz, lb);
      n_tests++;
      if (la != 33 || a_code !== 8'h00 || a_match !== 1'b0) begin
         n_fail++; $display("FAIL stuck0: lat %0d code %h match %b want 33 00 0", la, a_code, a_match);
      end
      mode = 2;
      sweep(la, lz, lb);
      n_tests++;
      if (la != 33 || a_code !== 8'hFF || a_match !== 1'b0) begin
         n_fail++; $display("FAIL stuck1: lat %0d code %h match %b want 33 ff 0", la, a_code, a_match);
      end
   endtask

   task automatic test_settle();
      int la, lz, lb;
      mode = 3;
      sweep(la, lz, lb);
      n_tests++;
      if (a_code !== 8'h3D || a_match !== 1'b1) begin
         n_fail++; $display("FAIL settle_s3: code %h match %b want 3d 1", a_code, a_match);
      end
      // Settle 0 samples vector i against f(i-2), with 000 before the sweep.
      n_tests++;
      if (lz != 9 || z_code !== 8'h0F || z_match !== 1'b0) begin
         n_fail++; $display("FAIL settle_s0: lat %0d code %h match %b want 9 0f 0", lz, z_code, z_match);
      end
   endtask

   task automatic test_back_to_back();
      int ndone, nidle, lat2;
      mode = 0; ndone = 0; nidle = 0; lat2 = -1;
      start = 1'b1;
      for (int k = 1; k <= 33; k++) begin
         @(negedge clk);
         if (a_done) ndone++;
         if (k < 33 && !a_busy) nidle++;
      end
      n_tests++;
      if (a_done !== 1'b1 || ndone != 1 || nidle != 0) begin
         n_fail++; $display("FAIL start_held: done %b pulses %0d idle_cycles %0d want 1 1 0", a_done, ndone, nidle);
      end
      @(negedge clk);
      start = 1'b0;
      n_tests++;
      if (a_busy !== 1'b1 || a_valid !== 1'b0 || a_code !== 8'h00 || a_done !== 1'b0) begin
         n_fail++; $display("FAIL restart_in_done: busy %b valid %b code %h done %b want 1 0 00 0",
                            a_busy, a_valid, a_code, a_done);
      end
      for (int k = 35; k <= 120 && lat2 < 0; k++) begin
         @(negedge clk);
         if (a_done) lat2 = k;
      end
      n_tests++;
      if (lat2 != 66 || a_code !== 8'h3D || a_match !== 1'b1) begin
         n_fail++; $display("FAIL restart_sweep: done at %0d code %h match %b want 66 3d 1", lat2, a_code, a_match);
      end
   endtask

   task automatic test_rst_mid();
      int seen, bad, la, lz, lb;
      mode = 0; seen = -1; bad = 0;
      rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
      start = 1'b1;
      for (int k = 1; k <= 100 && seen < 0; k++) begin
         @(negedge clk);
         start = 1'b0;
         if ({a_in1, a_in2, a_in3} == 3'b100) seen = k;
      end
      n_tests++;
      if (seen != 17) begin n_fail++; $display("FAIL idx4_cycle: got %0d want 17", seen); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if ({a_in1, a_in2, a_in3, a_busy, a_done, a_valid, a_match} !== 7'b0 || a_code !== 8'h00) begin
         n_fail++; $display("FAIL rst_mid: ctrl %b code %h want 0000000 00",
                            {a_in1, a_in2, a_in3, a_busy, a_done, a_valid, a_match}, a_code);
      end
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (a_done || a_busy || a_valid) bad++;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL rst_no_done: active cycles %0d want 0", bad); end
      sweep(la, lz, lb);
      n_tests++;
      if (la != 33 || a_code !== 8'h3D || a_match !== 1'b1) begin
         n_fail++; $display("FAIL after_rst: lat %0d code %h match %b want 33 3d 1", la, a_code, a_match);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; mode = 0;
      test_reset();
      test_correct_gate();
      test_stuck();
      test_settle();
      test_back_to_back();
      test_rst_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
